// File: rtl/conv_line_buffer_mc.sv
// Multi-channel double-buffered row buffer feeding the conv kernel array.
// Rows rotate through NSLOT circular slots; a spare slot fills while the window is read.
module conv_line_buffer_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int BUFFER_ROW = 3,
  parameter int BUFFER_COL = 8,
  parameter int CHANNEL    = 1,
  localparam int RW = (BUFFER_ROW > 2) ? $clog2(BUFFER_ROW) : 1,
  localparam int VW = $clog2(BUFFER_ROW + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic [CHANNEL*DATA_WIDTH-1:0]            data_in,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     pad_row,
  input  logic                                     advance,
  input  logic [RW-1:0]                            rd_row,
  output logic [CHANNEL*BUFFER_COL*DATA_WIDTH-1:0] data_out_bus,
  output logic [VW-1:0]                            rows_valid,
  output logic                                     window_valid,
  output logic                                     adv_err
);

  localparam int NSLOT = BUFFER_ROW + 1;
  localparam int SW    = $clog2(NSLOT);
  localparam int CW    = $clog2(BUFFER_COL);

  logic [DATA_WIDTH-1:0] mem [NSLOT][CHANNEL][BUFFER_COL];

  logic [SW-1:0] head;
  logic [SW-1:0] fill_slot;
  logic [SW-1:0] rd_slot;
  logic [SW-1:0] head_inc;
  logic [CW-1:0] wr_col;
  logic          pending;
  logic          accept;
  logic          last_col;
  logic          pad_ok;
  logic          row_done;
  logic          commit;

  // NSLOT need not be a power of two, so wrap by compare
  function automatic logic [SW-1:0] wrap_add(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SW+1)'(NSLOT))
      s = s - (SW+1)'(NSLOT);
    return s[SW-1:0];
  endfunction

  assign fill_slot    = wrap_add(head, SW'(rows_valid));
  assign rd_slot      = wrap_add(head, SW'(rd_row));
  assign head_inc     = wrap_add(head, SW'(1));
  assign window_valid = (rows_valid == VW'(BUFFER_ROW));
  assign in_ready     = !pending && !pad_row;
  assign accept       = in_valid && in_ready;
  assign last_col     = (wr_col == CW'(BUFFER_COL - 1));
  assign pad_ok       = pad_row && (wr_col == '0) && !pending;
  assign row_done     = (accept && last_col) || pad_ok;
  assign commit       = row_done || pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      wr_col     <= '0;
      rows_valid <= '0;
      pending    <= 1'b0;
      adv_err    <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      wr_col     <= '0;
      rows_valid <= '0;
      pending    <= 1'b0;
      adv_err    <= 1'b0;
    end else begin
      if (accept)
        wr_col <= last_col ? '0 : wr_col + CW'(1);
      if ((pad_row && !pad_ok) || (advance && !window_valid))
        adv_err <= 1'b1;
      if (commit) begin
        if (!window_valid) begin
          rows_valid <= rows_valid + VW'(1);
          pending    <= 1'b0;
        end else if (advance) begin
          head    <= head_inc;
          pending <= 1'b0;
        end else begin
          pending <= 1'b1;
        end
      end else if (advance && window_valid) begin
        head       <= head_inc;
        rows_valid <= rows_valid - VW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSLOT; s++)
        for (int c = 0; c < CHANNEL; c++)
          for (int k = 0; k < BUFFER_COL; k++)
            mem[s][c][k] <= '0;
    end else if (!flush) begin
      if (pad_ok) begin
        for (int c = 0; c < CHANNEL; c++)
          for (int k = 0; k < BUFFER_COL; k++)
            mem[fill_slot][c][k] <= '0;
      end else if (accept) begin
        for (int c = 0; c < CHANNEL; c++)
          mem[fill_slot][c][wr_col] <=
            data_in[(c+1)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  // fill slot is never addressed here: rd_row < rows_valid
  always_comb begin
    data_out_bus = '0;
    if (SW'(rd_row) < SW'(rows_valid)) begin
      for (int c = 0; c < CHANNEL; c++)
        for (int k = 0; k < BUFFER_COL; k++)
          data_out_bus[((c*BUFFER_COL)+(BUFFER_COL-k))*DATA_WIDTH-1 -: DATA_WIDTH] =
            mem[rd_slot][c][k];
    end
  end

endmodule

// File: tb/tb_conv_line_buffer_mc.sv
// Directed bench for conv_line_buffer_mc: table-driven vectors plus
// hand sequences for pad, flush and asynchronous reset.
module tb_conv_line_buffer_mc;

  localparam int DW = 32;
  localparam int BR = 3;
  localparam int BC = 8;
  localparam int CH = 2;
  localparam int RW = 2;
  localparam int VW = 2;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic [CH*DW-1:0]   data_in;
  logic               in_valid;
  logic               in_ready;
  logic               pad_row;
  logic               advance;
  logic [RW-1:0]      rd_row;
  logic [CH*BC*DW-1:0] data_out_bus;
  logic [VW-1:0]      rows_valid;
  logic               window_valid;
  logic               adv_err;

  conv_line_buffer_mc #(
    .DATA_WIDTH(DW),
    .BUFFER_ROW(BR),
    .BUFFER_COL(BC),
    .CHANNEL(CH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .data_in(data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pad_row(pad_row),
    .advance(advance),
    .rd_row(rd_row),
    .data_out_bus(data_out_bus),
    .rows_valid(rows_valid),
    .window_valid(window_valid),
    .adv_err(adv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    logic pad;
    logic adv;
    logic fl;
    int   val;
    logic rdy;
    int   rows;
    logic err;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic pad, input logic adv,
                     input logic fl, input int val, input logic rdy,
                     input int rows, input logic err);
    vec_t v;
    v.iv = iv; v.pad = pad; v.adv = adv; v.fl = fl;
    v.val = val; v.rdy = rdy; v.rows = rows; v.err = err;
    vq.push_back(v);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    pad_row  = 1'b0;
    advance  = 1'b0;
    flush    = 1'b0;
    data_in  = '0;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    in_valid = v.iv;
    pad_row  = v.pad;
    advance  = v.adv;
    flush    = v.fl;
    data_in  = {DW'(v.val + 100), DW'(v.val)};
    @(posedge clk);
    #1;
    idle();
    #1;
    chk($sformatf("vec%0d in_ready", idx), longint'(in_ready), longint'(v.rdy));
    chk($sformatf("vec%0d rows_valid", idx), longint'(rows_valid), longint'(v.rows));
    chk($sformatf("vec%0d adv_err", idx), longint'(adv_err), longint'(v.err));
    chk($sformatf("vec%0d window_valid", idx), longint'(window_valid),
        longint'(v.rows == BR));
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++)
      step(vq[i], i);
    vq.delete();
  endtask

  task automatic chk_px(input string nm, input int rr, input int c,
                        input int k, input int exp);
    logic [DW-1:0] act;
    rd_row = RW'(rr);
    #1;
    act = data_out_bus[((c*BC)+(BC-k))*DW-1 -: DW];
    chk(nm, longint'(act), longint'(exp));
  endtask

  task automatic chk_zero(input string nm, input int rr);
    rd_row = RW'(rr);
    #1;
    chk(nm, longint'(data_out_bus == '0), 1);
  endtask

  initial begin
    idle();
    rd_row = '0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset rows_valid", longint'(rows_valid), 0);
    chk("reset window_valid", longint'(window_valid), 0);
    chk("reset adv_err", longint'(adv_err), 0);
    chk_zero("reset bus", 0);
    rst_n = 1'b1;

    // preload three rows
    for (int i = 1; i <= 24; i++)
      add(1, 0, 0, 0, i, 1, i / 8, 0);
    run_table();
    chk_px("pre r0c0 ch0", 0, 0, 0, 1);
    chk_px("pre r0c0 ch1", 0, 1, 0, 101);
    chk_px("pre r2c7 ch0", 2, 0, 7, 24);
    chk_px("pre r2c7 ch1", 2, 1, 7, 124);

    // backpressure: fourth row stalls until advance
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 0, 25 + i, (i == 7) ? 1'b0 : 1'b1, 3, 0);
    add(1, 0, 0, 0, 99, 0, 3, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0);
    run_table();
    chk_px("bp r0c0", 0, 0, 0, 9);
    chk_px("bp r1c0", 1, 0, 0, 17);
    chk_px("bp r2c0", 2, 0, 0, 25);
    chk_px("bp r2c7", 2, 0, 7, 32);

    // overlapped slide, five rows to wrap head
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 8; k++)
        add(1, 0, (k == 7), 0, 200 + 8*r + k, 1, 3, 0);
    run_table();
    chk_px("ov r0c0 ch0", 0, 0, 0, 216);
    chk_px("ov r0c0 ch1", 0, 1, 0, 316);
    chk_px("ov r1c3", 1, 0, 3, 227);
    chk_px("ov r2c7", 2, 0, 7, 239);

    add(0, 0, 1, 0, 0, 1, 2, 0);
    run_table();
    chk_px("ret r0c0", 0, 0, 0, 224);
    chk_px("ret r1c0", 1, 0, 0, 232);
    chk_zero("ret r2 hidden", 2);

    // padding after flush; pad wins over in_valid
    add(0, 0, 0, 1, 0, 1, 0, 0);
    run_table();
    @(negedge clk);
    pad_row  = 1'b1;
    in_valid = 1'b1;
    data_in  = {DW'(655), DW'(555)};
    #1;
    chk("pad in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("pad rows_valid", longint'(rows_valid), 1);
    chk("pad adv_err", longint'(adv_err), 0);
    for (int i = 1; i <= 16; i++)
      add(1, 0, 0, 0, 300 + i, 1, 1 + i / 8, 0);
    for (int i = 1; i <= 3; i++)
      add(1, 0, 0, 0, 400 + i, 1, 3, 0);
    add(0, 1, 0, 0, 0, 1, 3, 1);
    run_table();
    chk_zero("pad r0 zero", 0);
    chk_px("pad r1c0", 1, 0, 0, 301);
    chk_px("pad r2c7 ch1", 2, 1, 7, 416);

    // errors and flush mid-row
    add(0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 0, 500 + i, 1, i / 8, 0);
    add(0, 0, 1, 0, 0, 1, 1, 1);
    for (int i = 1; i <= 5; i++)
      add(1, 0, 0, 0, 510 + i, 1, 1, 1);
    add(1, 0, 0, 1, 516, 1, 0, 0);
    run_table();
    chk_zero("flush bus", 0);
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 0, 600 + i, 1, i / 8, 0);
    run_table();
    chk_px("postflush c0", 0, 0, 0, 601);
    chk_px("postflush c7 ch1", 0, 1, 7, 708);

    // asynchronous reset between clock edges
    add(0, 0, 1, 0, 0, 1, 1, 1);
    for (int i = 1; i <= 3; i++)
      add(1, 0, 0, 0, 700 + i, 1, 1, 1);
    run_table();
    rd_row = '0;
    rst_n  = 1'b0;
    #1;
    chk("arst in_ready", longint'(in_ready), 1);
    chk("arst rows_valid", longint'(rows_valid), 0);
    chk("arst window_valid", longint'(window_valid), 0);
    chk("arst adv_err", longint'(adv_err), 0);
    chk_zero("arst bus", 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++)
      add(1, 0, 0, 0, 800 + i, 1, i / 8, 0);
    run_table();
    chk_px("arst r0c0", 0, 0, 0, 801);
    chk_px("arst r0c7", 0, 0, 7, 808);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
